// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ADD/SUB/AND/OR/SLL with valid/ready handshakes on both sides.
// Define ALU_EXEC_FAST_SHIFT_EN for a single-cycle barrel shifter instead of the iterative one.
module alu_exec_unit #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b1000;

`ifdef ALU_EXEC_FAST_SHIFT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   shl_s;
`endif

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               illegal_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH-1:0]   acc_res_d;
  logic               acc_ill_d;
  logic               acc_shift_d;

  // Result of the operation presented at the inputs, used on the accept edge.
  always_comb begin
    shamt_s     = b[SHAMT_W-1:0];
    acc_res_d   = '0;
    acc_ill_d   = 1'b0;
    acc_shift_d = 1'b0;
    case (operation)
      OP_ADD: acc_res_d = a + b;
      OP_SUB: acc_res_d = a - b;
      OP_AND: acc_res_d = a & b;
      OP_OR:  acc_res_d = a | b;
      OP_SLL: begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
        acc_res_d = a << shamt_s;
`else
        // Zero shift completes immediately; otherwise a is preloaded and shifted in place.
        acc_res_d   = a;
        acc_shift_d = (shamt_s != '0);
`endif
      end
      default: acc_ill_d = 1'b1;
    endcase
  end

`ifndef ALU_EXEC_FAST_SHIFT_EN
  assign shl_s = {result_q[WIDTH-2:0], 1'b0};
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            result_q   <= acc_res_d;
            zero_q     <= (acc_res_d == '0);
            illegal_q  <= acc_ill_d;
            in_ready_q <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            if (acc_shift_d) begin
              cnt_q   <= shamt_s;
              state_q <= S_SHIFT;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end
`else
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
`endif
          end
        end
`ifndef ALU_EXEC_FAST_SHIFT_EN
        S_SHIFT: begin
          result_q <= shl_s;
          zero_q   <= (shl_s == '0);
          cnt_q    <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        illegal;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(64), .SHAMT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv);
    exp_t       e;
    logic [5:0] sh;
    sh    = bv[5:0];
    e.res = 64'd0;
    e.ill = 1'b0;
    e.lat = 1;
    case (op)
      4'b0010: e.res = av + bv;
      4'b0110: e.res = av - bv;
      4'b0000: e.res = av & bv;
      4'b0001: e.res = av | bv;
      4'b1000: begin
        e.res = av << sh;
`ifndef ALU_EXEC_FAST_SHIFT_EN
        if (sh != 6'd0) e.lat = int'(sh) + 1;
`endif
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 64'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, compare against the scoreboard; leaves the DUT in DONE.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv);
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    in_valid  = 1'b1;
    operation = op;
    a         = av;
    b         = bv;
    sb_q.push_back(model(op, av, bv));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    operation = 4'b1111;
    a         = ~av;
    b         = ~bv;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    e = sb_q.pop_front();
    chk({tag, "_valid"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_result"},  result, e.res);
      chk({tag, "_zero"},    64'(zero), 64'(e.zero));
      chk({tag, "_illegal"}, 64'(illegal), 64'(e.ill));
      chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    end
  endtask

  // Called at a negedge while in DONE: hand the result off and confirm return to IDLE.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_in_ready"},  64'(in_ready), 64'd1);
    chk({tag, "_idle_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    bit stray;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    operation = 4'b0000;
    a         = 64'd0;
    b         = 64'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    result, 64'd0);
    chk("rst_zero",      64'(zero), 64'd1);
    chk("rst_illegal",   64'(illegal), 64'd0);

    run_op("add_5_7", 4'b0010, 64'd5, 64'd7);
    chk("add_5_7_const", result, 64'd12);
    consume("add_5_7");
    run_op("sub_9_9", 4'b0110, 64'd9, 64'd9);
    chk("sub_9_9_zero_const", 64'(zero), 64'd1);
    consume("sub_9_9");
    run_op("sub_0_1", 4'b0110, 64'd0, 64'd1);
    chk("sub_0_1_const", result, 64'hFFFF_FFFF_FFFF_FFFF);
    consume("sub_0_1");
    run_op("and", 4'b0000, 64'hF0F0, 64'hFF00);
    chk("and_const", result, 64'hF000);
    consume("and");
    run_op("or", 4'b0001, 64'hF0F0, 64'hFF00);
    chk("or_const", result, 64'hFFF0);
    consume("or");
    run_op("sll_63", 4'b1000, 64'd1, 64'd63);
    chk("sll_63_const", result, 64'h8000_0000_0000_0000);
    consume("sll_63");
    run_op("sll_0", 4'b1000, 64'd3, 64'h140);
    chk("sll_0_const", result, 64'd3);
    consume("sll_0");
    run_op("sll_5", 4'b1000, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFC5);
    consume("sll_5");

    run_op("illegal", 4'b0111, 64'd5, 64'd7);
    chk("illegal_const", 64'(illegal), 64'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      operation = 4'b0010;
      a         = 64'd1;
      b         = 64'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready",  64'(in_ready), 64'd0);
      chk("bp_result",    result, 64'd0);
      chk("bp_zero",      64'(zero), 64'd1);
      chk("bp_illegal",   64'(illegal), 64'd1);
    end
    consume("bp");
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_extra_valid", 64'(out_valid), 64'd0);
    end
    run_op("add_after_ill", 4'b0010, 64'd100, 64'd23);
    chk("ill_cleared", 64'(illegal), 64'd0);
    consume("add_after_ill");

    @(negedge clk);
    in_valid  = 1'b1;
    operation = 4'b1000;
    a         = 64'd1;
    b         = 64'd40;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
`ifndef ALU_EXEC_FAST_SHIFT_EN
    chk("midshift_busy", 64'(in_ready), 64'd0);
`endif
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result",    result, 64'd0);
    chk("midrst_zero",      64'(zero), 64'd1);
    chk("midrst_illegal",   64'(illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    chk("midrst_no_result", 64'(stray), 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
